// File: rtl/lfsr_checker.sv
// lfsr_checker: serial receive-side checker for the 7-bit (WIDTH-bit)
// pseudo-random sequence of the LFSR generator with feedback
// s[1]^s[5]^s[3]^s[2]. The checker fills a local copy of the register from
// the incoming bits (HUNT), then predicts every following bit and flags
// mismatches (CHECK).
//
// Optional feature: define LFSR_CHK_AUTORESYNC_EN to drop back to HUNT after
// LOSS_THRESH consecutive mismatches. Without it the checker stays locked
// until reset.
module lfsr_checker #(
  parameter int WIDTH       = 7,
  parameter int LOSS_THRESH = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_bit,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [WIDTH-1:0]     local_state
);

  localparam int                FILL_W     = $clog2(WIDTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(WIDTH);
  localparam logic [3:0]        MISS_LIMIT = 4'(LOSS_THRESH);

  typedef enum logic {
    HUNT  = 1'b0,
    CHECK = 1'b1
  } state_t;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     s_reg, s_next;
  logic [FILL_W-1:0]    fill_reg, fill_next;
  logic [3:0]           miss_reg, miss_next;
  logic [CNT_WIDTH-1:0] err_count_reg, err_count_next;
  logic                 err_pulse_reg, err_pulse_next;

  // Shared combinational terms
  logic                 exp_bit;
  logic [WIDTH-1:0]     hunt_shift;
  logic [WIDTH-1:0]     check_shift;
  logic [FILL_W-1:0]    fill_inc;
  logic                 miss_hit;
  logic                 bit_err;

  // Predicted bit, shifted register candidates, fill/miss helpers
  always_comb begin
    exp_bit     = s_reg[1] ^ s_reg[5] ^ s_reg[3] ^ s_reg[2];
    hunt_shift  = {s_reg[WIDTH-2:0], in_bit};
    check_shift = {s_reg[WIDTH-2:0], exp_bit};
    fill_inc    = (fill_reg == FILL_FULL) ? fill_reg : fill_reg + FILL_W'(1);
    // This mismatch would be the LOSS_THRESH-th in a row
    miss_hit    = ({1'b0, miss_reg} + 5'd1) >= {1'b0, MISS_LIMIT};
    bit_err     = in_bit != exp_bit;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= HUNT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: lock on a full, non-zero fill; optional lock loss
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HUNT: begin
        if (in_valid && (fill_inc == FILL_FULL) && (hunt_shift != '0)) begin
          state_next = CHECK;
        end
      end
      CHECK: begin
`ifdef LFSR_CHK_AUTORESYNC_EN
        if (in_valid && bit_err && miss_hit) begin
          state_next = HUNT;
        end
`endif
      end
      default: state_next = HUNT;
    endcase
  end

  // Output/datapath logic: register fill, prediction, error strobe and counts
  always_comb begin
    s_next         = s_reg;
    fill_next      = fill_reg;
    miss_next      = miss_reg;
    err_count_next = err_count_reg;
    err_pulse_next = 1'b0;
    if (in_valid) begin
      case (state_reg)
        HUNT: begin
          // Slide raw received bits in; an all-zero window keeps sliding
          s_next    = hunt_shift;
          fill_next = fill_inc;
          miss_next = '0;
        end
        CHECK: begin
          // Predicted bit goes into the register so a line error never
          // corrupts the local copy
          s_next = check_shift;
          if (bit_err) begin
            err_pulse_next = 1'b1;
            if (err_count_reg != '1) begin
              err_count_next = err_count_reg + CNT_WIDTH'(1);
            end
            miss_next = miss_hit ? MISS_LIMIT : miss_reg + 4'd1;
`ifdef LFSR_CHK_AUTORESYNC_EN
            if (miss_hit) begin
              s_next    = '0;
              fill_next = '0;
              miss_next = '0;
            end
`endif
          end else begin
            miss_next = '0;
          end
        end
        default: begin
          s_next = s_reg;
        end
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_reg         <= '0;
      fill_reg      <= '0;
      miss_reg      <= '0;
      err_count_reg <= '0;
      err_pulse_reg <= 1'b0;
    end else begin
      s_reg         <= s_next;
      fill_reg      <= fill_next;
      miss_reg      <= miss_next;
      err_count_reg <= err_count_next;
      err_pulse_reg <= err_pulse_next;
    end
  end

  assign locked      = (state_reg == CHECK);
  assign err_pulse   = err_pulse_reg;
  assign err_count   = err_count_reg;
  assign local_state = s_reg;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: scoreboard bench for lfsr_checker. A driver issues one
// stimulus per cycle and pushes the reference model's expected outputs; a
// monitor pops and compares after every rising edge.
module tb_lfsr_checker;

  localparam int W  = 7;
  localparam int LT = 4;
  localparam int CW = 16;
`ifdef LFSR_CHK_AUTORESYNC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_bit;
  logic          locked;
  logic          err_pulse;
  logic [CW-1:0] err_count;
  logic [W-1:0]  local_state;

  always #5 clk = ~clk;

  lfsr_checker #(.WIDTH(W), .LOSS_THRESH(LT), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .local_state(local_state)
  );

  typedef struct {
    logic          lk;
    logic          ep;
    logic [CW-1:0] cnt;
    logic [W-1:0]  st;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: the local bit stream (newest at the back); the
  // predicted bit is a recurrence over bits 2,3,4,6 positions back.
  bit   m_hist[$];
  bit   m_lock;
  int   m_fill;
  int   m_miss;
  int   m_cnt;
  bit   m_pulse;
  logic [6:0] gen;

  function automatic bit hb(input int k);
    if (m_hist.size() >= k) return m_hist[m_hist.size() - k];
    return 1'b0;
  endfunction

  function automatic int m_state();
    int v = 0;
    for (int k = 0; k < W; k++) if (hb(k + 1)) v = v | (1 << k);
    return v;
  endfunction

  function automatic bit gen_next();
    bit nb;
    nb  = gen[1] ^ gen[5] ^ gen[3] ^ gen[2];
    gen = {gen[5:0], nb};
    return nb;
  endfunction

  task automatic model_step(input bit r, input bit v, input bit b);
    bit e;
    m_pulse = 1'b0;
    if (r) begin
      m_hist.delete();
      m_lock = 1'b0; m_fill = 0; m_miss = 0; m_cnt = 0;
    end else if (v) begin
      if (!m_lock) begin
        m_hist.push_back(b);
        if (m_fill < W) m_fill++;
        if (m_fill == W && m_state() != 0) begin
          m_lock = 1'b1;
          m_miss = 0;
        end
      end else begin
        e = hb(2) ^ hb(6) ^ hb(4) ^ hb(3);
        m_hist.push_back(e);
        if (b != e) begin
          m_pulse = 1'b1;
          if (m_cnt < (1 << CW) - 1) m_cnt++;
          m_miss++;
          if (AUTO && m_miss >= LT) begin
            m_lock = 1'b0; m_fill = 0; m_miss = 0;
            m_hist.delete();
          end
        end else begin
          m_miss = 0;
        end
      end
      if (m_hist.size() > 32) void'(m_hist.pop_front());
    end
  endtask

  // Drive one cycle at the falling edge and queue the expected outputs
  task automatic drive(input bit r, input bit v, input bit b);
    exp_t x;
    @(negedge clk);
    reset = r; in_valid = v; in_bit = b;
    model_step(r, v, b);
    x.lk  = m_lock;
    x.ep  = m_pulse;
    x.cnt = CW'(m_cnt);
    x.st  = W'(m_state());
    sbq.push_back(x);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
  endtask

  // Clean generator bits, every cycle valid
  task automatic clean(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, gen_next());
  endtask

  // Inverted generator bits, every cycle valid
  task automatic inverted(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, ~gen_next());
  endtask

  // Monitor: compare DUT outputs one time unit after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        total++;
        if (locked !== e.lk || err_pulse !== e.ep || err_count !== e.cnt ||
            local_state !== e.st) begin
          bad++;
          $display("FAIL outputs t=%0t got locked=%0b err_pulse=%0b err_count=%0d local_state=%0h want locked=%0b err_pulse=%0b err_count=%0d local_state=%0h",
                   $time, locked, err_pulse, err_count, local_state,
                   e.lk, e.ep, e.cnt, e.st);
        end
      end
    end
  end

  initial begin
    bit v, b;
    reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0;
    m_lock = 1'b0; m_fill = 0; m_miss = 0; m_cnt = 0; m_pulse = 1'b0;

    // Reset state, then clean seed-5 stream for 500 bits
    do_reset();
    gen = 7'd5;
    clean(500);

    // Single flipped bit at the 20th checked bit
    do_reset();
    gen = 7'd5;
    clean(W + 19);
    inverted(1);
    clean(30);

    // Ten zeros while hunting, then the generator stream
    do_reset();
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0);
    gen = 7'd5;
    clean(40);

    // Burst of LOSS_THRESH inverted bits after lock, then clean bits
    do_reset();
    gen = 7'd5;
    clean(15);
    inverted(LT);
    clean(20);

    // in_valid alternating on a clean stream, random in_bit when invalid
    do_reset();
    gen = 7'd5;
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) drive(1'b0, 1'b1, gen_next());
      else            drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end

    // Randomized rounds: random seed, gaps, bit errors, mid-run resets
    for (int r = 0; r < 8; r++) begin
      do_reset();
      gen = 7'($urandom_range(1, 127));
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 199) == 0) begin
          drive(1'b1, 1'b0, 1'b0);
        end else begin
          v = ($urandom_range(0, 3) != 0);
          b = v ? gen_next() : 1'($urandom_range(0, 1));
          if (v && $urandom_range(0, 15) == 0) b = ~b;
          drive(1'b0, v, b);
        end
      end
    end

    // Counter saturation with continuous errors, then reset mid-operation
    do_reset();
    gen = 7'd5;
    clean(W);
    inverted(65540);
    do_reset();
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    // Let the monitor drain the scoreboard, bounded by a cycle budget
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
    #2;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
